// File: rtl/l2_word_memory.sv
// rtl/l2_word_memory.sv - word backing store below dcache, fixed-latency L2 request port
// Holds one LOAD/STORE/CLFLUSH request for LATENCY cycles, then pulses l2_req_fulfilled.

package xentry_pkg;
  typedef enum logic [1:0] {
    LOAD    = 2'b00,
    STORE   = 2'b01,
    CLFLUSH = 2'b10
  } memory_operation_e;
endpackage

module l2_word_memory
  import xentry_pkg::*;
#(
  parameter int              XLEN         = 32,
  parameter int              DEPTH_WORDS  = 2048,
  parameter int              LATENCY      = 4,
  parameter logic [XLEN-1:0] DEFAULT_WORD = 32'hACAB_0012
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [XLEN-1:0]   l2_req_address,
  input  memory_operation_e l2_req_type,
  input  logic              l2_req_valid,
  input  logic [XLEN-1:0]   l2_word_to_store,
  output logic [XLEN-1:0]   l2_fetched_word,
  output logic              l2_req_fulfilled,
  output logic              l2_busy
);

  localparam int IW = $clog2(DEPTH_WORDS);
  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  typedef enum logic [1:0] {IDLE, WAIT, RESPOND} state_e;

  state_e            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [IW-1:0]     idx_q, idx_d;
  memory_operation_e op_q, op_d;
  logic [XLEN-1:0]   wdata_q, wdata_d;
  logic [XLEN-1:0]   fetched_q, fetched_d;

  // Contents start at DEFAULT_WORD and are deliberately left alone by reset.
  logic [XLEN-1:0]   mem [DEPTH_WORDS] = '{default: DEFAULT_WORD};

  logic              enter_respond;
  logic              mem_we;
  logic [IW-1:0]     eff_idx;
  memory_operation_e eff_op;
  logic [XLEN-1:0]   eff_wdata;

  logic unused_addr;
  assign unused_addr = ^{l2_req_address[1:0], l2_req_address[XLEN-1:2+IW]};

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    idx_d         = idx_q;
    op_d          = op_q;
    wdata_d       = wdata_q;
    fetched_d     = fetched_q;
    enter_respond = 1'b0;
    eff_idx       = idx_q;
    eff_op        = op_q;
    eff_wdata     = wdata_q;

    case (state_q)
      IDLE: begin
        if (l2_req_valid) begin
          idx_d     = l2_req_address[2 +: IW];
          op_d      = l2_req_type;
          wdata_d   = l2_word_to_store;
          cnt_d     = CW'(LATENCY - 1);
          // With LATENCY==1 the access happens on the accepting edge, so use the live inputs.
          eff_idx   = l2_req_address[2 +: IW];
          eff_op    = l2_req_type;
          eff_wdata = l2_word_to_store;
          if (LATENCY == 1) begin
            state_d       = RESPOND;
            enter_respond = 1'b1;
          end else begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CW'(1)) begin
          state_d       = RESPOND;
          enter_respond = 1'b1;
        end
      end
      RESPOND: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    mem_we = enter_respond && (eff_op == STORE);
    if (enter_respond && (eff_op == LOAD)) begin
      fetched_d = mem[eff_idx];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      idx_q     <= '0;
      op_q      <= LOAD;
      wdata_q   <= '0;
      fetched_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      op_q      <= op_d;
      wdata_q   <= wdata_d;
      fetched_q <= fetched_d;
    end
  end

  // Reset suppresses a write that was due on the same edge.
  always_ff @(posedge clk) begin
    if (!reset && mem_we) begin
      mem[eff_idx] <= eff_wdata;
    end
  end

  assign l2_fetched_word  = fetched_q;
  assign l2_req_fulfilled = (state_q == RESPOND);
  assign l2_busy          = (state_q != IDLE);

endmodule

// File: tb/tb_l2_word_memory.sv
// tb/tb_l2_word_memory.sv - directed self-checking bench for l2_word_memory
// Unit 0 runs with LATENCY=4, unit 1 with LATENCY=1; both share clock and reset.

module tb_l2_word_memory;
  import xentry_pkg::*;

  logic              clk = 1'b0;
  logic              reset;
  logic [31:0]       req_addr  [2];
  logic [31:0]       req_wdata [2];
  memory_operation_e req_type  [2];
  logic              req_valid [2];
  logic [31:0]       fetched   [2];
  logic              fulfilled [2];
  logic              busy      [2];

  int checks = 0;
  int passed = 0;
  int lat;
  logic seen;

  always #5 clk = ~clk;

  l2_word_memory #(.XLEN(32), .DEPTH_WORDS(2048), .LATENCY(4), .DEFAULT_WORD(32'hACAB_0012)) dut4 (
    .clk(clk), .reset(reset),
    .l2_req_address(req_addr[0]), .l2_req_type(req_type[0]), .l2_req_valid(req_valid[0]),
    .l2_word_to_store(req_wdata[0]), .l2_fetched_word(fetched[0]),
    .l2_req_fulfilled(fulfilled[0]), .l2_busy(busy[0])
  );

  l2_word_memory #(.XLEN(32), .DEPTH_WORDS(2048), .LATENCY(1), .DEFAULT_WORD(32'hACAB_0012)) dut1 (
    .clk(clk), .reset(reset),
    .l2_req_address(req_addr[1]), .l2_req_type(req_type[1]), .l2_req_valid(req_valid[1]),
    .l2_word_to_store(req_wdata[1]), .l2_fetched_word(fetched[1]),
    .l2_req_fulfilled(fulfilled[1]), .l2_busy(busy[1])
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Called at #1 after an edge with the unit idle; returns at #1 after the edge leaving RESPOND.
  task automatic do_req(input int u, input memory_operation_e op, input logic [31:0] addr,
                        input logic [31:0] data, input bit hold_valid, output int lat_o);
    req_type[u]  = op;
    req_addr[u]  = addr;
    req_wdata[u] = data;
    req_valid[u] = 1'b1;
    @(posedge clk); #1;
    check("busy_after_accept", 32'(busy[u]), 32'd1);
    req_addr[u]  = ~addr;
    req_wdata[u] = ~data;
    req_type[u]  = (op == STORE) ? LOAD : STORE;
    if (!hold_valid) req_valid[u] = 1'b0;
    lat_o = 1;
    while (!fulfilled[u] && lat_o < 20) begin
      @(posedge clk); #1;
      lat_o++;
    end
    req_valid[u] = 1'b0;
    @(posedge clk); #1;
    check("pulse_width", 32'(fulfilled[u]), 32'd0);
    check("busy_after_done", 32'(busy[u]), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int u = 0; u < 2; u++) begin
      req_addr[u] = '0; req_wdata[u] = '0; req_type[u] = LOAD; req_valid[u] = 1'b0;
    end
    reset = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check("rst_fetched", fetched[0], 32'h0);
    check("rst_fulfilled", 32'(fulfilled[0]), 32'd0);
    check("rst_busy", 32'(busy[0]), 32'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    // Test 1: default content, latency 4
    do_req(0, LOAD, 32'h0000_0104, 32'h0, 1'b1, lat);
    check("t1_lat", lat, 4);
    check("t1_data", fetched[0], 32'hACAB_0012);

    // Test 2: store then load; neighbour untouched; valid dropped early on the store
    do_req(0, STORE, 32'h0000_0040, 32'hFEED_BEEF, 1'b0, lat);
    check("t2_store_lat", lat, 4);
    check("t2_store_keeps_fetched", fetched[0], 32'hACAB_0012);
    do_req(0, LOAD, 32'h0000_0040, 32'h0, 1'b1, lat);
    check("t2_load_back", fetched[0], 32'hFEED_BEEF);
    do_req(0, LOAD, 32'h0000_0044, 32'h0, 1'b1, lat);
    check("t2_neighbour", fetched[0], 32'hACAB_0012);

    // Test 4: CLFLUSH writes nothing and leaves fetched_word alone
    do_req(0, CLFLUSH, 32'h0000_0040, 32'h0BAD_0BAD, 1'b1, lat);
    check("t4_flush_lat", lat, 4);
    check("t4_flush_fetched", fetched[0], 32'hACAB_0012);
    do_req(0, memory_operation_e'(2'b11), 32'h0000_0040, 32'h0BAD_0BAD, 1'b1, lat);
    check("t4_unknown_lat", lat, 4);
    do_req(0, LOAD, 32'h0000_0040, 32'h0, 1'b1, lat);
    check("t4_load_after_flush", fetched[0], 32'hFEED_BEEF);

    // Test 3: upper address bits alias, byte bits ignored
    do_req(0, STORE, 32'h0000_2040, 32'h1234_5678, 1'b1, lat);
    do_req(0, LOAD, 32'h0000_0040, 32'h0, 1'b1, lat);
    check("t3_alias", fetched[0], 32'h1234_5678);
    do_req(0, LOAD, 32'h0000_0043, 32'h0, 1'b1, lat);
    check("t3_byte_bits", fetched[0], 32'h1234_5678);

    // Test 5: reset on the edge that would complete the store
    req_type[0] = STORE; req_addr[0] = 32'h80; req_wdata[0] = 32'hDEAD_0001; req_valid[0] = 1'b1;
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      reset = 1'b0;
      seen |= fulfilled[0];
    end
    check("t5_no_pulse", 32'(seen), 32'd0);
    check("t5_busy", 32'(busy[0]), 32'd0);
    check("t5_fetched_reset", fetched[0], 32'h0);
    do_req(0, LOAD, 32'h0000_0080, 32'h0, 1'b1, lat);
    check("t5_no_write", fetched[0], 32'hACAB_0012);

    // Reset and valid together: request not accepted
    reset = 1'b1;
    req_type[0] = STORE; req_addr[0] = 32'hC0; req_wdata[0] = 32'h1111_2222; req_valid[0] = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0; req_valid[0] = 1'b0;
    check("rv_busy", 32'(busy[0]), 32'd0);
    @(posedge clk); #1;
    check("rv_busy_later", 32'(busy[0]), 32'd0);
    do_req(0, LOAD, 32'h0000_00C0, 32'h0, 1'b1, lat);
    check("rv_no_write", fetched[0], 32'hACAB_0012);

    // LATENCY=1 unit: clflush sequence
    do_req(1, CLFLUSH, 32'h10, 32'h0, 1'b1, lat);
    check("l1_flush_lat", lat, 1);
    do_req(1, LOAD, 32'h10, 32'h0, 1'b1, lat);
    check("l1_load_lat", lat, 1);
    check("l1_load_default", fetched[1], 32'hACAB_0012);
    do_req(1, CLFLUSH, 32'h10, 32'h0, 1'b1, lat);
    do_req(1, LOAD, 32'h10, 32'h0, 1'b1, lat);
    do_req(1, STORE, 32'h10, 32'h55AA_33CC, 1'b1, lat);
    check("l1_store_lat", lat, 1);
    check("l1_store_keeps_fetched", fetched[1], 32'hACAB_0012);
    do_req(1, CLFLUSH, 32'h10, 32'h0, 1'b1, lat);
    do_req(1, LOAD, 32'h10, 32'h0, 1'b1, lat);
    check("l1_final_load", fetched[1], 32'h55AA_33CC);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
